// File: rtl/rr_mux8.sv
// rr_mux8: 8-channel round-robin 1-bit multiplexer with per-grant hold time.
module rr_mux8 #(
  parameter int unsigned HOLD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic [7:0] req,
  input  logic       en,
  output logic       dout,
  output logic [2:0] sel,
  output logic       dout_vld,
  output logic [7:0] ack,
  output logic       busy
);

  localparam int unsigned NCH = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned CW  = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state, state_nxt;
  logic [SW-1:0]  ptr, ptr_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [SW-1:0]  sel_nxt;
  logic           dout_nxt;
  logic           vld_nxt;
  logic [NCH-1:0] ack_nxt;
  logic           busy_nxt;

  logic [SW-1:0]  scan_base_c;
  logic [SW-1:0]  pick_c;
  logic           pick_vld_c;
  logic           grant_end_c;
  logic           start_c;

  // Scan starts at ptr when idle, at sel+1 (the pointer being loaded) at grant end.
  assign scan_base_c = (state == GRANT) ? (sel + SW'(1)) : ptr;
  assign grant_end_c = (state == GRANT) && ((cnt == '0) || !req[sel]);
  assign start_c     = ((state == IDLE) || grant_end_c) && en && pick_vld_c;

  // Round-robin arbiter: first requesting channel at or after scan_base_c.
  always_comb begin
    logic [SW-1:0] idx;
    idx        = '0;
    pick_c     = '0;
    pick_vld_c = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = scan_base_c + SW'(i);
      if (req[idx]) begin
        pick_c     = idx;
        pick_vld_c = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && pick_vld_c) state_nxt = GRANT;
      GRANT:   if (grant_end_c && !(en && pick_vld_c)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for pointer, hold counter and registered outputs.
  always_comb begin
    ptr_nxt  = ptr;
    cnt_nxt  = cnt;
    sel_nxt  = sel;
    dout_nxt = dout;
    vld_nxt  = dout_vld;
    ack_nxt  = ack;
    busy_nxt = (state_nxt == GRANT);
    if (grant_end_c) ptr_nxt = sel + SW'(1);
    if (start_c) begin
      sel_nxt  = pick_c;
      dout_nxt = din[pick_c];
      vld_nxt  = 1'b1;
      ack_nxt  = NCH'(1) << pick_c;
      cnt_nxt  = CW'(HOLD - 1);
    end else if (grant_end_c) begin
      vld_nxt = 1'b0;
      ack_nxt = '0;
    end else if (state == GRANT) begin
      dout_nxt = din[sel];
      if (cnt != '0) cnt_nxt = cnt - CW'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      cnt      <= '0;
      sel      <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      sel      <= sel_nxt;
      dout     <= dout_nxt;
      dout_vld <= vld_nxt;
      ack      <= ack_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rr_mux8.sv
// tb_rr_mux8: three rr_mux8 instances (HOLD = 1, 3, 4) on shared inputs, checked against a behavioural model.
module tb_rr_mux8;

  localparam int NI = 3;
  localparam int HOLDS [NI] = '{1, 3, 4};

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [7:0] req;
  logic       en;

  logic       dout_o [NI];
  logic [2:0] sel_o  [NI];
  logic       vld_o  [NI];
  logic [7:0] ack_o  [NI];
  logic       busy_o [NI];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state per instance: owner = granted channel or -1.
  int owner  [NI];
  int served [NI];
  int mptr   [NI];
  int msel   [NI];
  bit mdout  [NI];

  rr_mux8 #(.HOLD(1)) u_h1 (.clk(clk), .rst_n(rst_n), .din(din), .req(req), .en(en),
    .dout(dout_o[0]), .sel(sel_o[0]), .dout_vld(vld_o[0]), .ack(ack_o[0]), .busy(busy_o[0]));
  rr_mux8 #(.HOLD(3)) u_h3 (.clk(clk), .rst_n(rst_n), .din(din), .req(req), .en(en),
    .dout(dout_o[1]), .sel(sel_o[1]), .dout_vld(vld_o[1]), .ack(ack_o[1]), .busy(busy_o[1]));
  rr_mux8 #(.HOLD(4)) u_h4 (.clk(clk), .rst_n(rst_n), .din(din), .req(req), .en(en),
    .dout(dout_o[2]), .sel(sel_o[2]), .dout_vld(vld_o[2]), .ack(ack_o[2]), .busy(busy_o[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int arb(input int p, input logic [7:0] r);
    for (int i = 0; i < 8; i++)
      if (r[(p + i) % 8]) return (p + i) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NI; j++) begin
      owner[j] = -1; served[j] = 0; mptr[j] = 0; msel[j] = 0; mdout[j] = 1'b0;
    end
  endtask

  task automatic model_start(input int j, input int c);
    owner[j] = c; msel[j] = c; mdout[j] = din[c]; served[j] = 1;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    for (int j = 0; j < NI; j++) begin
      if (owner[j] < 0) begin
        if (en && req != 8'h00) model_start(j, arb(mptr[j], req));
      end else if (served[j] >= HOLDS[j] || !req[owner[j]]) begin
        mptr[j]  = (owner[j] + 1) % 8;
        owner[j] = -1;
        if (en && req != 8'h00) model_start(j, arb(mptr[j], req));
      end else begin
        served[j]++;
        mdout[j] = din[owner[j]];
      end
    end
  endtask

  task automatic check_all(input string ph);
    logic [7:0] ack_e;
    for (int j = 0; j < NI; j++) begin
      ack_e = (owner[j] >= 0) ? (8'h01 << msel[j]) : 8'h00;
      chk($sformatf("%s_vld_h%0d", ph, HOLDS[j]),  32'(vld_o[j]),  32'(owner[j] >= 0));
      chk($sformatf("%s_busy_h%0d", ph, HOLDS[j]), 32'(busy_o[j]), 32'(owner[j] >= 0));
      chk($sformatf("%s_sel_h%0d", ph, HOLDS[j]),  32'(sel_o[j]),  32'(msel[j]));
      chk($sformatf("%s_dout_h%0d", ph, HOLDS[j]), 32'(dout_o[j]), 32'(mdout[j]));
      chk($sformatf("%s_ack_h%0d", ph, HOLDS[j]),  32'(ack_o[j]),  32'(ack_e));
    end
  endtask

  task automatic check_zero(input string ph);
    for (int j = 0; j < NI; j++) begin
      chk($sformatf("%s_rvld_h%0d", ph, HOLDS[j]),  32'(vld_o[j]),  32'd0);
      chk($sformatf("%s_rbusy_h%0d", ph, HOLDS[j]), 32'(busy_o[j]), 32'd0);
      chk($sformatf("%s_rsel_h%0d", ph, HOLDS[j]),  32'(sel_o[j]),  32'd0);
      chk($sformatf("%s_rdout_h%0d", ph, HOLDS[j]), 32'(dout_o[j]), 32'd0);
      chk($sformatf("%s_rack_h%0d", ph, HOLDS[j]),  32'(ack_o[j]),  32'd0);
    end
  endtask

  // Advance one clock: model updates at the rising edge, outputs are checked at the falling edge.
  task automatic cyc(input string ph);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(ph);
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear before the next edge.
  task automatic async_reset(input string ph);
    #2 rst_n = 1'b0;
    #1 check_zero(ph);
    model_reset();
    #1 rst_n = 1'b1;
    check_zero({ph, "_rel"});
  endtask

  initial begin
    logic [7:0] dpat;
    rst_n = 1'b0; din = 8'h00; req = 8'h00; en = 1'b0;
    model_reset();
    #3 check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle");

    // HOLD=1 rotation with all channels requesting.
    dpat = 8'b1010_0101;
    din = dpat; req = 8'hFF; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc("rot");
      chk($sformatf("rot_sel_%0d", i),  32'(sel_o[0]),  32'(i % 8));
      chk($sformatf("rot_ack_%0d", i),  32'(ack_o[0]),  32'(8'h01 << (i % 8)));
      chk($sformatf("rot_dout_%0d", i), 32'(dout_o[0]), 32'(dpat[i % 8]));
    end

    // HOLD=3 alternating between channels 2 and 4.
    async_reset("s33");
    req = 8'b0001_0100;
    for (int i = 0; i < 9; i++) begin
      cyc("alt");
      chk($sformatf("alt_sel_%0d", i), 32'(sel_o[1]), (i / 3 == 1) ? 32'd4 : 32'd2);
    end

    // HOLD=4 early release on channel 5, then pointer must sit at 6.
    async_reset("s34");
    req = 8'h20;
    cyc("early_g");
    chk("early_grant_sel", 32'(sel_o[2]), 32'd5);
    req = 8'h00;
    cyc("early_r");
    chk("early_rel_vld", 32'(vld_o[2]), 32'd0);
    req = 8'hFF;
    cyc("early_ptr");
    chk("early_ptr_sel", 32'(sel_o[2]), 32'd6);

    // Enable gating of new grants.
    async_reset("s35");
    en = 1'b0; req = 8'h80;
    for (int i = 0; i < 3; i++) begin
      cyc("en_lo");
      chk($sformatf("en_lo_vld_%0d", i), 32'(vld_o[0]), 32'd0);
    end
    en = 1'b1;
    cyc("en_hi");
    chk("en_hi_sel", 32'(sel_o[0]), 32'd7);
    chk("en_hi_ack", 32'(ack_o[0]), 32'h80);

    // Reset mid-grant on channel 3, then restart scanning from channel 0.
    async_reset("s36a");
    req = 8'h08;
    cyc("g3");
    chk("g3_sel", 32'(sel_o[1]), 32'd3);
    async_reset("mid");
    req = 8'h09;
    cyc("after_rst");
    chk("after_rst_sel", 32'(sel_o[1]), 32'd0);
    chk("after_rst_ack", 32'(ack_o[1]), 32'h01);

    // en dropping during a grant does not abort it.
    async_reset("s23");
    req = 8'h02; en = 1'b1;
    cyc("en_drop_g");
    en = 1'b0;
    cyc("en_drop_1");
    chk("en_drop_keep", 32'(vld_o[2]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      din = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = 8'h00;
      else if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      else req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 120) == 0) async_reset("rnd_rst");
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
